// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

   // Arbiter FSM state; the 2-bit encoding is also what shows up in traces.
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_FETCH = 2'd1,
      ARB_DATA  = 2'd2
   } arb_state_e;

   // Which requester currently owns the memory port, for debug traces.
   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } arb_owner_e;

   // Consecutive data grants tolerated while fetch waits (legal range 1..15).
   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
   localparam int unsigned CNT_W_DEFAULT        = 4;

   // Map an FSM state to the owner it represents.
   function automatic arb_owner_e owner_of(input arb_state_e s);
      arb_owner_e o;
      o = OWN_NONE;
      case (s)
         ARB_FETCH: o = OWN_FETCH;
         ARB_DATA:  o = OWN_DATA;
         default:   o = OWN_NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of consecutive data grants taken while fetch was waiting.
// clr has priority over inc; the count never moves past LIMIT.
module starve_counter #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned LIMIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             limit_reached_o
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, increment only while below the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < LIMIT_C)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o           = cnt_q;
   assign limit_reached_o = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between
// instruction fetch (read only) and the memory stage (byte/word read/write).
//
//  state     | meaning
//  ----------|-----------------------------------------------------------
//  ARB_IDLE  | no access in flight; pick a winner among eligible requesters
//  ARB_FETCH | fetch read outstanding; mem_* held until mem_ack
//  ARB_DATA  | data access outstanding; mem_* held until mem_ack
//
// Data wins by default (the memory-stage instruction is older); once
// STARVE_LIMIT data grants have been made back to back over a waiting fetch,
// fetch is forced through. A requester whose done flag is high is not
// eligible, so a req that has not been dropped yet cannot re-win the port
// in its own done cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
   parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_done,
   output logic [31:0] fetch_rdata,
   input  logic        data_req,
   input  logic        data_we,
   input  logic        data_byte,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_done,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_byte,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall_fetch,
   output logic        stall_mem
);

   arb_state_e  state_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic        mem_byte_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        fetch_done_q;
   logic        data_done_q;
   logic [31:0] fetch_rdata_q;
   logic [31:0] data_rdata_q;

   logic             fetch_elig;
   logic             data_elig;
   logic             grant_data;
   logic             grant_fetch;
   logic             cnt_inc;
   logic             cnt_clr;
   logic             limit_reached;
   logic [CNT_W-1:0] starve_cnt;

   // Grant decision, only meaningful while idle.
   always_comb begin
      fetch_elig  = fetch_req & ~fetch_done_q;
      data_elig   = data_req & ~data_done_q;
      grant_data  = 1'b0;
      grant_fetch = 1'b0;
      if (state_q == ARB_IDLE) begin
         grant_data  = data_elig & (~fetch_elig | ~limit_reached);
         grant_fetch = fetch_elig & ~grant_data;
      end
      cnt_inc = grant_data & fetch_elig;
      cnt_clr = grant_fetch | (grant_data & ~fetch_elig);
   end

   starve_counter #(
      .CNT_W (CNT_W),
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock           (clock),
      .reset           (reset),
      .inc_i           (cnt_inc),
      .clr_i           (cnt_clr),
      .cnt_o           (starve_cnt),
      .limit_reached_o (limit_reached)
   );

   // Arbiter FSM with registered memory-side and requester-side outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ARB_IDLE;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_byte_q    <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         fetch_done_q  <= 1'b0;
         data_done_q   <= 1'b0;
         fetch_rdata_q <= '0;
         data_rdata_q  <= '0;
      end else begin
         fetch_done_q <= 1'b0;
         data_done_q  <= 1'b0;
         unique case (state_q)
            ARB_IDLE: begin
               if (grant_data) begin
                  state_q     <= ARB_DATA;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= data_we;
                  mem_byte_q  <= data_byte;
                  mem_addr_q  <= data_addr;
                  mem_wdata_q <= data_wdata;
               end else if (grant_fetch) begin
                  state_q     <= ARB_FETCH;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_byte_q  <= 1'b0;
                  mem_addr_q  <= fetch_addr;
                  mem_wdata_q <= '0;
               end
            end
            ARB_FETCH: begin
               if (mem_ack) begin
                  state_q       <= ARB_IDLE;
                  mem_req_q     <= 1'b0;
                  fetch_done_q  <= 1'b1;
                  fetch_rdata_q <= mem_rdata;
               end
            end
            ARB_DATA: begin
               if (mem_ack) begin
                  state_q     <= ARB_IDLE;
                  mem_req_q   <= 1'b0;
                  data_done_q <= 1'b1;
                  // A write returns nothing; keep the last read value.
                  if (!mem_we_q) begin
                     data_rdata_q <= mem_rdata;
                  end
               end
            end
            default: begin
               state_q   <= ARB_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_byte    = mem_byte_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign fetch_done  = fetch_done_q;
   assign data_done   = data_done_q;
   assign fetch_rdata = fetch_rdata_q;
   assign data_rdata  = data_rdata_q;

   assign stall_fetch = fetch_req & ~fetch_done_q;
   assign stall_mem   = data_req & ~data_done_q;

   // The starvation count can never exceed its limit.
   a_cnt_bound: assert property (@(posedge clock) disable iff (reset)
      starve_cnt <= CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a behavioural model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_done;
   logic [31:0] fetch_rdata;
   logic        data_req;
   logic        data_we;
   logic        data_byte;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_done;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_we;
   logic        mem_byte;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall_fetch;
   logic        stall_mem;

   always #5 clock = ~clock;

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_done  (fetch_done),
      .fetch_rdata (fetch_rdata),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_byte   (data_byte),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_done   (data_done),
      .data_rdata  (data_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_byte    (mem_byte),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .stall_fetch (stall_fetch),
      .stall_mem   (stall_mem)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      fetch_req  = 1'b0;
      fetch_addr = '0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      data_byte  = 1'b0;
      data_addr  = '0;
      data_wdata = '0;
      mem_ack    = 1'b0;
      mem_rdata  = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        fr;
      logic [31:0] fa;
      logic        dr, we, by;
      logic [31:0] da, wd;
      logic        ack;
      logic [31:0] rd;
      logic        e_req, e_we, e_by;
      logic [31:0] e_addr, e_wd;
      logic        e_fd, e_dd;
      logic [31:0] e_frd, e_drd;
      logic        e_sf, e_sm;
      int          e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(
      input logic fr, input logic [31:0] fa, input logic dr, input logic we, input logic by,
      input logic [31:0] da, input logic [31:0] wd, input logic ack, input logic [31:0] rd,
      input logic e_req, input logic e_we, input logic e_by, input logic [31:0] e_addr,
      input logic [31:0] e_wd, input logic e_fd, input logic e_dd, input logic [31:0] e_frd,
      input logic [31:0] e_drd, input logic e_sf, input logic e_sm, input int e_cnt);
      vec_t r;
      r.fr = fr; r.fa = fa; r.dr = dr; r.we = we; r.by = by; r.da = da; r.wd = wd;
      r.ack = ack; r.rd = rd; r.e_req = e_req; r.e_we = e_we; r.e_by = e_by;
      r.e_addr = e_addr; r.e_wd = e_wd; r.e_fd = e_fd; r.e_dd = e_dd; r.e_frd = e_frd;
      r.e_drd = e_drd; r.e_sf = e_sf; r.e_sm = e_sm; r.e_cnt = e_cnt;
      return r;
   endfunction

   task automatic fill_table();
      // single fetch, ack in second mem_req cycle
      tbl.push_back(v(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 32'h0040_0000, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(v(1, 32'h0040_0000, 0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 32'h0040_0000, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(v(1, 32'h0040_0000, 0, 0, 0, 0, 0, 1, 32'h2008_0005, 0, 0, 0, 32'h0040_0000, 0, 1, 0, 32'h2008_0005, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 32'h0040_0000, 0, 0, 0, 32'h2008_0005, 0, 0, 0, 0));
      // byte write; data_req held through done must not re-grant
      tbl.push_back(v(0, 0, 1, 1, 1, 32'h1001_0003, 32'hAB, 0, 0,            1, 1, 1, 32'h1001_0003, 32'hAB, 0, 0, 32'h2008_0005, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 1, 1, 1, 32'h1001_0003, 32'hAB, 0, 0,            1, 1, 1, 32'h1001_0003, 32'hAB, 0, 0, 32'h2008_0005, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 1, 1, 1, 32'h1001_0003, 32'hAB, 1, 32'hDEADBEEF, 0, 1, 1, 32'h1001_0003, 32'hAB, 0, 1, 32'h2008_0005, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 1, 1, 32'h1001_0003, 32'hAB, 0, 0,            0, 1, 1, 32'h1001_0003, 32'hAB, 0, 0, 32'h2008_0005, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0,                             0, 1, 1, 32'h1001_0003, 32'hAB, 0, 0, 32'h2008_0005, 0, 0, 0, 0));
      // simultaneous requests: data first, fetch granted in the data done cycle
      tbl.push_back(v(1, 32'h0040_0004, 1, 0, 0, 32'h1001_0000, 32'h1111_1111, 0, 0,            1, 0, 0, 32'h1001_0000, 32'h1111_1111, 0, 0, 32'h2008_0005, 0, 1, 1, 1));
      tbl.push_back(v(1, 32'h0040_0004, 1, 0, 0, 32'h1001_0000, 32'h1111_1111, 1, 32'hCAFEF00D, 0, 0, 0, 32'h1001_0000, 32'h1111_1111, 0, 1, 32'h2008_0005, 32'hCAFEF00D, 1, 0, 1));
      tbl.push_back(v(1, 32'h0040_0004, 1, 0, 0, 32'h1001_0000, 32'h1111_1111, 0, 0,            1, 0, 0, 32'h0040_0004, 0, 0, 0, 32'h2008_0005, 32'hCAFEF00D, 1, 1, 0));
      tbl.push_back(v(1, 32'h0040_0004, 0, 0, 0, 0, 0, 1, 32'h0123_4567,                        0, 0, 0, 32'h0040_0004, 0, 1, 0, 32'h0123_4567, 32'hCAFEF00D, 0, 0, 0));
      // fetch_req held through done: no grant in done cycle, grant the cycle after
      tbl.push_back(v(1, 32'h0040_0004, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 32'h0040_0004, 0, 0, 0, 32'h0123_4567, 32'hCAFEF00D, 1, 0, 0));
      tbl.push_back(v(1, 32'h0040_0008, 0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 32'h0040_0008, 0, 0, 0, 32'h0123_4567, 32'hCAFEF00D, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D,            0, 0, 0, 32'h0040_0008, 0, 1, 0, 32'h0BAD_F00D, 32'hCAFEF00D, 0, 0, 0));
      // stray ack while idle
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777,            0, 0, 0, 32'h0040_0008, 0, 0, 0, 32'h0BAD_F00D, 32'hCAFEF00D, 0, 0, 0));
   endtask

   task automatic run_table();
      foreach (tbl[i]) begin
         fetch_req  = tbl[i].fr;
         fetch_addr = tbl[i].fa;
         data_req   = tbl[i].dr;
         data_we    = tbl[i].we;
         data_byte  = tbl[i].by;
         data_addr  = tbl[i].da;
         data_wdata = tbl[i].wd;
         mem_ack    = tbl[i].ack;
         mem_rdata  = tbl[i].rd;
         tick();
         chk($sformatf("v%0d_mem_req", i),     32'(mem_req),     32'(tbl[i].e_req));
         chk($sformatf("v%0d_mem_we", i),      32'(mem_we),      32'(tbl[i].e_we));
         chk($sformatf("v%0d_mem_byte", i),    32'(mem_byte),    32'(tbl[i].e_by));
         chk($sformatf("v%0d_mem_addr", i),    mem_addr,         tbl[i].e_addr);
         chk($sformatf("v%0d_mem_wdata", i),   mem_wdata,        tbl[i].e_wd);
         chk($sformatf("v%0d_fetch_done", i),  32'(fetch_done),  32'(tbl[i].e_fd));
         chk($sformatf("v%0d_data_done", i),   32'(data_done),   32'(tbl[i].e_dd));
         chk($sformatf("v%0d_fetch_rdata", i), fetch_rdata,      tbl[i].e_frd);
         chk($sformatf("v%0d_data_rdata", i),  data_rdata,       tbl[i].e_drd);
         chk($sformatf("v%0d_stall_fetch", i), 32'(stall_fetch), 32'(tbl[i].e_sf));
         chk($sformatf("v%0d_stall_mem", i),   32'(stall_mem),   32'(tbl[i].e_sm));
         chk($sformatf("v%0d_starve_cnt", i),  32'(dut.starve_cnt), 32'(tbl[i].e_cnt));
      end
      clear_inputs();
   endtask

   // ---------------- reset in the middle of a data access ----------------
   task automatic run_reset_mid();
      clear_inputs();
      fetch_req  = 1'b1;
      fetch_addr = 32'h0040_0010;
      data_req   = 1'b1;
      data_addr  = 32'h1001_0010;
      tick();
      chk("rm_granted_req", 32'(mem_req), 32'd1);
      chk("rm_granted_addr", mem_addr, 32'h1001_0010);
      chk("rm_cnt_before", 32'(dut.starve_cnt), 32'd1);
      tick();
      chk("rm_second_cycle_req", 32'(mem_req), 32'd1);
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      fetch_req = 1'b0;
      data_req  = 1'b0;
      chk("rm_req_dropped", 32'(mem_req), 32'd0);
      chk("rm_no_done", 32'(data_done), 32'd0);
      chk("rm_state", 32'(dut.state_q), 32'(ARB_IDLE));
      chk("rm_cnt", 32'(dut.starve_cnt), 32'd0);
      chk("rm_addr", mem_addr, 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'h9999_9999;
      tick();
      mem_ack = 1'b0;
      chk("rm_stray_data_done", 32'(data_done), 32'd0);
      chk("rm_stray_fetch_done", 32'(fetch_done), 32'd0);
      chk("rm_stray_req", 32'(mem_req), 32'd0);
      chk("rm_stray_rdata", data_rdata, 32'd0);
      chk("rm_stray_state", 32'(dut.state_q), 32'(ARB_IDLE));
   endtask

   // ---------------- starvation limit ----------------
   // Data is held high; fetch withdraws only during data done cycles, so it is
   // waiting at every data grant. Expect 4 data grants, 1 fetch, then data.
   task automatic run_starve();
      logic is_data [6];
      int   exp_cnt [6];
      int   ng;
      logic prev;
      is_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      exp_cnt = '{1, 2, 3, 4, 0, 0};
      ng   = 0;
      prev = 1'b0;
      apply_reset();
      for (int c = 0; c < 100 && ng < 6; c++) begin
         fetch_req  = ~data_done;
         fetch_addr = 32'h0040_0100;
         data_req   = 1'b1;
         data_we    = 1'b0;
         data_addr  = 32'h1001_0100;
         mem_ack    = mem_req;
         mem_rdata  = 32'(c);
         tick();
         if (mem_req && !prev) begin
            chk($sformatf("starve_grant%0d_is_data", ng), 32'(mem_addr[28]), 32'(is_data[ng]));
            chk($sformatf("starve_grant%0d_cnt", ng), 32'(dut.starve_cnt), 32'(exp_cnt[ng]));
            ng++;
         end
         prev = mem_req;
      end
      chk("starve_grants_seen", 32'(ng), 32'd6);
      clear_inputs();
   endtask

   // ---------------- behavioural reference model ----------------
   int          m_owner;   // 0 none, 1 fetch, 2 data
   logic        m_req, m_we, m_by, m_fd, m_dd;
   logic [31:0] m_addr, m_wd, m_frd, m_drd;
   int          m_wins;    // consecutive data wins over a waiting fetch

   task automatic model_clear();
      m_owner = 0; m_req = 0; m_we = 0; m_by = 0; m_fd = 0; m_dd = 0;
      m_addr = 0; m_wd = 0; m_frd = 0; m_drd = 0; m_wins = 0;
   endtask

   task automatic model_step();
      bit fe, de;
      if (reset) begin
         model_clear();
         return;
      end
      fe   = fetch_req && !m_fd;
      de   = data_req && !m_dd;
      m_fd = 0;
      m_dd = 0;
      if (m_owner != 0) begin
         if (mem_ack) begin
            if (m_owner == 1) begin
               m_fd  = 1;
               m_frd = mem_rdata;
            end else begin
               m_dd = 1;
               if (!m_we) m_drd = mem_rdata;
            end
            m_owner = 0;
            m_req   = 0;
         end
      end else if (de && (!fe || m_wins < LIMIT)) begin
         m_owner = 2; m_req = 1;
         m_we = data_we; m_by = data_byte; m_addr = data_addr; m_wd = data_wdata;
         m_wins = fe ? ((m_wins + 1 > LIMIT) ? LIMIT : m_wins + 1) : 0;
      end else if (fe) begin
         m_owner = 1; m_req = 1;
         m_we = 0; m_by = 0; m_addr = fetch_addr; m_wd = 0;
         m_wins = 0;
      end
   endtask

   task automatic check_model(input int cyc);
      string t;
      t = $sformatf("rnd%0d_", cyc);
      chk({t, "mem_req"},     32'(mem_req),     32'(m_req));
      chk({t, "mem_we"},      32'(mem_we),      32'(m_we));
      chk({t, "mem_byte"},    32'(mem_byte),    32'(m_by));
      chk({t, "mem_addr"},    mem_addr,         m_addr);
      chk({t, "mem_wdata"},   mem_wdata,        m_wd);
      chk({t, "fetch_done"},  32'(fetch_done),  32'(m_fd));
      chk({t, "data_done"},   32'(data_done),   32'(m_dd));
      chk({t, "fetch_rdata"}, fetch_rdata,      m_frd);
      chk({t, "data_rdata"},  data_rdata,       m_drd);
      chk({t, "stall_fetch"}, 32'(stall_fetch), 32'(fetch_req & ~m_fd));
      chk({t, "stall_mem"},   32'(stall_mem),   32'(data_req & ~m_dd));
      chk({t, "starve_cnt"},  32'(dut.starve_cnt), 32'(m_wins));
   endtask

   task automatic run_random(input int cycles);
      apply_reset();
      model_clear();
      for (int c = 0; c < cycles; c++) begin
         reset      = ($urandom_range(0, 99) == 0);
         fetch_req  = ($urandom_range(0, 3) != 0);
         fetch_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         data_req   = ($urandom_range(0, 2) != 0);
         data_we    = $urandom_range(0, 1) != 0;
         data_byte  = $urandom_range(0, 1) != 0;
         data_addr  = $urandom;
         data_wdata = $urandom;
         mem_ack    = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         mem_rdata  = $urandom;
         @(posedge clock);
         model_step();
         @(negedge clock);
         check_model(c);
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      reset = 1'b1;
      fill_table();
      @(negedge clock);
      tick();
      tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_byte", 32'(mem_byte), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_fetch_done", 32'(fetch_done), 32'd0);
      chk("rst_data_done", 32'(data_done), 32'd0);
      chk("rst_fetch_rdata", fetch_rdata, 32'd0);
      chk("rst_data_rdata", data_rdata, 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
      chk("rst_cnt", 32'(dut.starve_cnt), 32'd0);
      reset = 1'b0;

      run_table();
      run_reset_mid();
      run_starve();
      run_random(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
